// File: rtl/prbs_pkg.sv
// Shared PRBS8 definitions (x^8+x^6+x^5+x^4+1) used by the generator and the checker.
package prbs_pkg;

  localparam int unsigned PRBS8_W     = 8;
  localparam int unsigned PRBS8_TAP_A = 7;
  localparam int unsigned PRBS8_TAP_B = 5;
  localparam int unsigned PRBS8_TAP_C = 4;
  localparam int unsigned PRBS8_TAP_D = 3;
  localparam logic [PRBS8_W-1:0] PRBS8_SEED = 8'hFF;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } prbs_chk_state_t;

  // Feedback / next expected bit from the 8-bit history
  function automatic logic prbs8_fb(input logic [PRBS8_W-1:0] s);
    return s[PRBS8_TAP_A] ^ s[PRBS8_TAP_B] ^ s[PRBS8_TAP_C] ^ s[PRBS8_TAP_D];
  endfunction

endpackage

// File: rtl/prbs8_checker_sat_counter.sv
// Saturating up-counter; clear and inc together yield 1.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(inc);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// PRBS8 receive checker: self-synchronises, locks, then counts errors against a flywheel copy.
module prbs8_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             sync_loss
);

  localparam int unsigned WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned ERR_W  = $clog2(WIN + 1);
  localparam int unsigned GOOD_W = 8;
  localparam int unsigned FILL_W = 3;

  prbs_chk_state_t     state, state_d;
  logic [PRBS8_W-1:0]  sr, sr_d;
  logic [FILL_W-1:0]   fill_cnt, fill_d;
  logic [GOOD_W-1:0]   good_cnt, good_d;
  logic [WIN_W-1:0]    win_cnt, win_cnt_d;
  logic [ERR_W-1:0]    win_err, win_err_d;
  logic                err_pulse_d, sync_loss_d;
  logic                exp_c, mismatch_c, bit_inc_c, err_inc_c;

  // Next-state and datapath decisions for one valid bit
  always_comb begin
    state_d     = state;
    sr_d        = sr;
    fill_d      = fill_cnt;
    good_d      = good_cnt;
    win_cnt_d   = win_cnt;
    win_err_d   = win_err;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    bit_inc_c   = 1'b0;
    err_inc_c   = 1'b0;
    exp_c       = prbs8_fb(sr);
    mismatch_c  = in_bit ^ exp_c;

    if (in_valid) begin
      unique case (state)
        FILL: begin
          sr_d   = {sr[PRBS8_W-2:0], in_bit};
          fill_d = fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_W'(PRBS8_W - 1)) begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        HUNT: begin
          sr_d = {sr[PRBS8_W-2:0], in_bit};
          // An all-zero history is a lockup, never evidence of sync
          if (!mismatch_c && (sr != '0)) begin
            if (32'(good_cnt) + 32'd1 >= LOCK_CNT) begin
              state_d   = LOCKED;
              good_d    = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              good_d = good_cnt + GOOD_W'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the local sequence advances on its own prediction
          sr_d        = {sr[PRBS8_W-2:0], exp_c};
          bit_inc_c   = 1'b1;
          err_inc_c   = mismatch_c;
          err_pulse_d = mismatch_c;
          win_cnt_d   = win_cnt + WIN_W'(1);
          if (32'(win_err) + 32'(mismatch_c) >= LOSS_THR) begin
            state_d     = FILL;
            sync_loss_d = 1'b1;
            sr_d        = '0;
            fill_d      = '0;
          end else if (win_cnt == WIN_W'(WIN - 1)) begin
            win_err_d = '0;
          end else begin
            win_err_d = win_err + ERR_W'(mismatch_c);
          end
        end
        default: begin
          state_d = FILL;
          sr_d    = '0;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      fill_cnt  <= fill_d;
      good_cnt  <= good_d;
      win_cnt   <= win_cnt_d;
      win_err   <= win_err_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_pulse_d;
      sync_loss <= sync_loss_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (err_inc_c),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (bit_inc_c),
    .count (bit_count)
  );

endmodule

// File: tb/tb_prbs8_checker.sv
// Self-checking bench for prbs8_checker against a bit-history reference model.
module tb_prbs8_checker;

  localparam int unsigned LOCK_CNT = 16;
  localparam int unsigned WIN      = 64;
  localparam int unsigned LOSS_THR = 8;
  localparam int unsigned CNT_W    = 32;
  localparam longint      CMAX     = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear = 1'b0;
  logic             locked, err_pulse, sync_loss;
  logic [CNT_W-1:0] err_count, bit_count;

  int errors = 0;
  int checks = 0;

  prbs8_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count),
    .sync_loss (sync_loss)
  );

  always #5 clk = ~clk;

  // Stream source: the team's LFSR seeded 8'hFF, feedback bit is the serial output
  logic [7:0] g;
  task automatic gen(output logic b);
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
  endtask

  // Reference model: mode 0=filling, 1=hunting, 2=locked; history holds the last 8 bits, oldest first
  int     m_mode, m_fill, m_good, m_wpos, m_werr;
  longint m_err, m_bits;
  logic   m_pulse, m_loss;
  logic   m_hist[$];

  function automatic logic m_locked();
    return m_mode == 2;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_good = 0; m_wpos = 0; m_werr = 0;
    m_err = 0; m_bits = 0; m_pulse = 0; m_loss = 0;
    m_hist.delete();
    for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
  endtask

  task automatic push_hist(input logic b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model(input logic v, input logic b, input logic clr);
    logic e, nz;
    m_pulse = 0;
    m_loss  = 0;
    if (clr) begin m_err = 0; m_bits = 0; end
    if (!v) return;
    // predicted bit = bits 8, 6, 5 and 4 positions back, xored
    e  = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
    nz = 0;
    foreach (m_hist[k]) nz |= m_hist[k];
    case (m_mode)
      0: begin
        push_hist(b);
        m_fill++;
        if (m_fill == 8) begin m_mode = 1; m_good = 0; end
      end
      1: begin
        push_hist(b);
        if (b == e && nz) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
        end else m_good = 0;
      end
      default: begin
        push_hist(e);
        if (m_bits < CMAX) m_bits++;
        if (b != e) begin
          m_pulse = 1;
          if (m_err < CMAX) m_err++;
        end
        if (m_werr + int'(b != e) >= LOSS_THR) begin
          m_mode = 0; m_loss = 1; m_fill = 0;
          foreach (m_hist[k]) m_hist[k] = 1'b0;
        end else if (m_wpos == WIN - 1) m_werr = 0;
        else m_werr += int'(b != e);
        m_wpos = (m_wpos + 1) % WIN;
      end
    endcase
  endtask

  // Drive one cycle, advance the model, return #1 after the edge
  task automatic cyc(input logic v, input logic b, input logic clr);
    @(negedge clk);
    in_valid = v; in_bit = b; clear = clr;
    model(v, b, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 0; in_bit = 0; clear = 0;
    repeat (2) @(posedge clk);
    model_reset();
    g = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 5;
    if (locked !== 1'b0)    begin errors++; $display("FAIL reset_locked got=%b want=0", locked); end
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
    if (sync_loss !== 1'b0) begin errors++; $display("FAIL reset_sync_loss got=%b want=0", sync_loss); end
    if (err_count !== '0)   begin errors++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    if (bit_count !== '0)   begin errors++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
  endtask

  task automatic test_clean();
    logic b; int lock_at = 0; int nloss = 0;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      gen(b); cyc(1, b, 0);
      checks++;
      if ({locked, err_pulse, sync_loss} !== {m_locked(), m_pulse, m_loss}) begin
        errors++; $display("FAIL clean_flags bit=%0d got=%b want=%b", i, {locked, err_pulse, sync_loss}, {m_locked(), m_pulse, m_loss});
      end
      if (locked && lock_at == 0) lock_at = i;
      nloss += int'(sync_loss);
    end
    checks += 4;
    if (lock_at != 24)       begin errors++; $display("FAIL clean_lock_bit got=%0d want=24", lock_at); end
    if (err_count !== 32'd0) begin errors++; $display("FAIL clean_err_count got=%0d want=0", err_count); end
    if (bit_count !== 32'd976) begin errors++; $display("FAIL clean_bit_count got=%0d want=976", bit_count); end
    if (nloss != 0)          begin errors++; $display("FAIL clean_sync_loss got=%0d want=0", nloss); end
  endtask

  task automatic test_single_error();
    logic b; int npulse = 0;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      gen(b); cyc(1, b ^ (i == 500), 0);
      checks++;
      if ({locked, err_pulse, sync_loss} !== {m_locked(), m_pulse, m_loss}) begin
        errors++; $display("FAIL single_flags bit=%0d got=%b want=%b", i, {locked, err_pulse, sync_loss}, {m_locked(), m_pulse, m_loss});
      end
      npulse += int'(err_pulse);
    end
    checks += 4;
    if (npulse != 1)           begin errors++; $display("FAIL single_pulses got=%0d want=1", npulse); end
    if (err_count !== 32'd1)   begin errors++; $display("FAIL single_err_count got=%0d want=1", err_count); end
    if (locked !== 1'b1)       begin errors++; $display("FAIL single_locked got=%b want=1", locked); end
    if (bit_count !== 32'd976) begin errors++; $display("FAIL single_bit_count got=%0d want=976", bit_count); end
  endtask

  task automatic test_burst_loss();
    logic b; int relock = 0;
    do_reset();
    for (int i = 1; i <= 100; i++) begin gen(b); cyc(1, b, 0); end
    for (int i = 1; i <= 8; i++) begin
      gen(b); cyc(1, ~b, 0);
      checks++;
      if (sync_loss !== (i == 8)) begin errors++; $display("FAIL burst_sync_loss inv=%0d got=%b want=%b", i, sync_loss, i == 8); end
    end
    checks += 2;
    if (locked !== 1'b0)     begin errors++; $display("FAIL burst_unlocked got=%b want=0", locked); end
    if (err_count !== 32'd8) begin errors++; $display("FAIL burst_err_count got=%0d want=8", err_count); end
    for (int i = 1; i <= 100 && relock == 0; i++) begin
      gen(b); cyc(1, b, 0);
      checks++;
      if ({locked, err_pulse, sync_loss} !== {m_locked(), m_pulse, m_loss}) begin
        errors++; $display("FAIL burst_flags bit=%0d got=%b want=%b", i, {locked, err_pulse, sync_loss}, {m_locked(), m_pulse, m_loss});
      end
      if (locked) relock = i;
    end
    checks += 2;
    if (relock != 24)        begin errors++; $display("FAIL burst_relock got=%0d want=24", relock); end
    if (err_count !== 32'd8) begin errors++; $display("FAIL burst_err_hold got=%0d want=8", err_count); end
  endtask

  task automatic test_all_zero();
    logic b; int lock_at = 0; int nlock = 0;
    do_reset();
    for (int i = 1; i <= 500; i++) begin cyc(1, 1'b0, 0); nlock += int'(locked); end
    checks += 2;
    if (nlock != 0)          begin errors++; $display("FAIL zero_locked got=%0d want=0", nlock); end
    if (err_count !== 32'd0) begin errors++; $display("FAIL zero_err_count got=%0d want=0", err_count); end
    g = 8'hFF;
    for (int i = 1; i <= 100 && lock_at == 0; i++) begin
      gen(b); cyc(1, b, 0);
      checks++;
      if (locked !== m_locked()) begin errors++; $display("FAIL zero_model_lock bit=%0d got=%b want=%b", i, locked, m_locked()); end
      if (locked) lock_at = i;
    end
    checks++;
    if (lock_at != 24) begin errors++; $display("FAIL zero_relock got=%0d want=24", lock_at); end
  endtask

  task automatic test_gapped();
    logic b; int lock_cyc = 0; int nvalid = 0;
    do_reset();
    for (int c = 1; c <= 400; c++) begin
      logic v;
      v = (c % 2) == 1;
      b = 1'b0;
      if (v) begin gen(b); nvalid++; end
      // corrupt a few valid bits once locked so there are pulses to watch
      cyc(v, b ^ (v && (nvalid % 37 == 0)), 0);
      checks += 2;
      if ({locked, err_pulse, sync_loss} !== {m_locked(), m_pulse, m_loss}) begin
        errors++; $display("FAIL gap_flags cyc=%0d got=%b want=%b", c, {locked, err_pulse, sync_loss}, {m_locked(), m_pulse, m_loss});
      end
      if (!v && (err_pulse || sync_loss)) begin errors++; $display("FAIL gap_idle_pulse cyc=%0d got=%b want=00", c, {err_pulse, sync_loss}); end
      if (locked && lock_cyc == 0) lock_cyc = c;
    end
    checks += 2;
    if (lock_cyc != 47)               begin errors++; $display("FAIL gap_lock_cycle got=%0d want=47", lock_cyc); end
    if (err_count !== 32'(m_err))     begin errors++; $display("FAIL gap_err_count got=%0d want=%0d", err_count, m_err); end
  endtask

  task automatic test_clear_with_error();
    logic b;
    do_reset();
    for (int i = 1; i <= 39; i++) begin
      gen(b); cyc(1, b ^ (i >= 30 && i <= 38 && (i % 2 == 0)), 0);
    end
    checks++;
    if (err_count !== 32'd5) begin errors++; $display("FAIL clear_pre_count got=%0d want=5", err_count); end
    gen(b); cyc(1, ~b, 1);
    checks += 3;
    if (err_count !== 32'd1) begin errors++; $display("FAIL clear_err_count got=%0d want=1", err_count); end
    if (bit_count !== 32'd1) begin errors++; $display("FAIL clear_bit_count got=%0d want=1", bit_count); end
    if (locked !== 1'b1)     begin errors++; $display("FAIL clear_locked got=%b want=1", locked); end
  endtask

  task automatic test_window_edge(input int last_err, input logic want_loss);
    logic b; int nloss = 0;
    do_reset();
    for (int i = 1; i <= 95; i++) begin
      gen(b); cyc(1, b ^ ((i >= 30 && i <= 36) || i == last_err), 0);
      nloss += int'(sync_loss);
    end
    checks += 3;
    if (nloss != int'(want_loss)) begin errors++; $display("FAIL window_%0d_loss got=%0d want=%0d", last_err, nloss, want_loss); end
    if (locked !== !want_loss)    begin errors++; $display("FAIL window_%0d_locked got=%b want=%b", last_err, locked, !want_loss); end
    if (err_count !== 32'd8)      begin errors++; $display("FAIL window_%0d_err_count got=%0d want=8", last_err, err_count); end
  endtask

  task automatic test_reset_while_locked();
    logic b;
    do_reset();
    for (int i = 1; i <= 60; i++) begin gen(b); cyc(1, b ^ (i == 59), 0); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (locked !== 1'b0)    begin errors++; $display("FAIL midrst_locked got=%b want=0", locked); end
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL midrst_err_pulse got=%b want=0", err_pulse); end
    if (sync_loss !== 1'b0) begin errors++; $display("FAIL midrst_sync_loss got=%b want=0", sync_loss); end
    if (err_count !== '0)   begin errors++; $display("FAIL midrst_err_count got=%0d want=0", err_count); end
    if (bit_count !== '0)   begin errors++; $display("FAIL midrst_bit_count got=%0d want=0", bit_count); end
  endtask

  task automatic test_random();
    logic b, v, flip, clr;
    do_reset();
    for (int c = 1; c <= 4000; c++) begin
      v    = $urandom_range(0, 3) != 0;
      flip = $urandom_range(0, 99) < 3;
      clr  = $urandom_range(0, 63) == 0;
      b    = 1'b0;
      if (v) gen(b);
      cyc(v, b ^ (v & flip), clr);
      checks += 3;
      if ({locked, err_pulse, sync_loss} !== {m_locked(), m_pulse, m_loss}) begin
        errors++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", c, {locked, err_pulse, sync_loss}, {m_locked(), m_pulse, m_loss});
      end
      if (err_count !== 32'(m_err))  begin errors++; $display("FAIL rand_err_count cyc=%0d got=%0d want=%0d", c, err_count, m_err); end
      if (bit_count !== 32'(m_bits)) begin errors++; $display("FAIL rand_bit_count cyc=%0d got=%0d want=%0d", c, bit_count, m_bits); end
    end
  endtask

  initial begin
    model_reset();
    g = 8'hFF;
    test_reset();
    test_clean();
    test_single_error();
    test_burst_loss();
    test_all_zero();
    test_gapped();
    test_clear_with_error();
    test_window_edge(89, 1'b0);
    test_window_edge(88, 1'b1);
    test_reset_while_locked();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Serial receiver-side checker for the team's 8-bit PRBS stream (polynomial x^8+x^6+x^5+x^4+1).
- Self-synchronises to an incoming bit stream, declares lock, then counts bit errors against a free-running local copy of the sequence.
- Declares loss of sync when errors exceed a windowed threshold.
- Sits at the far end of a link or loopback, opposite the PRBS generator, for BIST and link bring-up.

Parameters:
LOCK_CNT, 16, consecutive matching bits in HUNT required to declare lock (1..255)
WIN, 64, window length in valid bits for the loss-of-sync check (power of 2, >= LOSS_THR)
LOSS_THR, 8, errors within one window that force loss of lock (1..WIN)
CNT_W, 32, width of err_count and bit_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_bit is a valid stream bit this cycle
in_bit  in  1  received serial PRBS bit
clear  in  1  synchronous clear of err_count and bit_count
locked  out  1  checker is in LOCKED state
err_pulse  out  1  one-cycle pulse: last valid bit mismatched while locked
err_count  out  CNT_W  saturating count of bit errors while locked
bit_count  out  CNT_W  saturating count of valid bits checked while locked
sync_loss  out  1  one-cycle pulse on the LOCKED -> FILL transition

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_count=0, bit_count=0, sync_loss=0, sr=8'h00, state=FILL, all internal counters 0.
- Shift register sr[7:0]:
  - A new bit enters at sr[0]; the contents shift toward sr[7].
  - Expected bit exp = sr[7]^sr[5]^sr[4]^sr[3].
- Cycles with in_valid=0 change nothing and produce no pulses. Gaps are transparent.
- FILL state:
  - Each valid bit shifts in_bit into sr; fill_cnt increments.
  - After the 8th valid bit, go to HUNT with good_cnt=0.
- HUNT state:
  - Each valid bit shifts in_bit into sr (self-synchronising).
  - Match (in_bit==exp) and sr!=0: good_cnt increments.
  - Mismatch, or sr==0 (all-zero lockup guard): good_cnt=0.
  - When good_cnt reaches LOCK_CNT: go to LOCKED, locked=1 at the same edge, win_cnt=0, win_err=0.
  - No errors are counted in HUNT.
- LOCKED state (flywheel):
  - Each valid bit shifts exp, not in_bit, into sr. One corrupted line bit therefore costs exactly one error.
  - bit_count increments, saturating at all-ones.
  - Mismatch: err_pulse=1 for the next cycle, err_count increments (saturating), win_err increments.
  - win_cnt increments per valid bit and wraps at WIN-1.
  - The threshold check includes the current bit: if win_err+mismatch >= LOSS_THR, go to FILL, locked=0, sync_loss=1 for one cycle, sr cleared, fill_cnt=0.
  - Otherwise, on the bit where win_cnt==WIN-1, win_err resets to 0.
- Latency: err_pulse, locked and sync_loss are visible the cycle after the edge that samples the decisive valid bit.
- clear:
  - Zeroes err_count and bit_count and does not affect state or lock.
  - clear in the same cycle as a counted error or bit gives a result of 1, not 0: clear first, then increment.
- Saturation: counters hold at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation returns everything to reset values immediately, whatever the state.
- Relock after sync_loss needs 8+LOCK_CNT further valid bits of a clean stream.

Decomposition:
- Shared package prbs_pkg, containing:
  - PRBS8 tap constants (indices 7,5,4,3) and seed constant 8'hFF, shared with the generator.
  - typedef enum logic [1:0] {FILL, HUNT, LOCKED} prbs_chk_state_t.
- One natural sub-module: sat_counter, a CNT_W-bit saturating counter with clear and inc, where clear+inc gives 1. It is instantiated for err_count and bit_count.
- Bench reference model: the existing 8-bit LFSR generator seeded 8'hFF, with its feedback bit as the serial stream. The first bits are 0,0,0,0,1.

Test Plan:
1. Clean generator stream, in_valid=1 continuously, defaults: locked rises after the 24th valid bit. After 1000 bits, err_count=0, bit_count=976, and sync_loss never pulses.
2. Locked, then invert a single bit at bit 500: exactly one err_pulse, err_count=1, locked stays 1, bit_count unaffected by the error.
3. Locked, then invert 8 consecutive bits: err_count=8 and sync_loss pulses on the 8th inverted bit. locked falls and relocks after 24 further clean bits. err_count stays 8.
4. Constant in_bit=0 for 500 bits: locked stays 0 and err_count=0 (all-zero guard). Switching to the clean stream then locks after 24 valid bits.
5. Clean stream with in_valid toggling 1,0,1,0: locked rises after the 24th valid bit (cycle 47). No pulses occur on invalid cycles.
6. Boundary and reset cases:
   - clear asserted in the same cycle as an error with err_count=5: err_count becomes 1.
   - 7 errors in window 1 then 1 error at the start of window 2: no sync_loss.
   - rst_n low while locked: all outputs 0 immediately.
